// File: rtl/blink_monitor.sv
// blink_monitor: measures high, low and period lengths of an asynchronous blink line and flags a stuck line
module blink_monitor #(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 led_in,
  output logic                 level,
  output logic [CNT_WIDTH-1:0] high_len,
  output logic [CNT_WIDTH-1:0] low_len,
  output logic [CNT_WIDTH:0]   period,
  output logic                 meas_valid,
  output logic                 stuck
);

  typedef enum logic {ACQ, RUN} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TIMEOUT - 1);

  state_t state, state_nxt;
  logic s1, sync_d, edg, rise, fall, timeout, have_hi;
  logic [CNT_WIDTH-1:0] run_cnt;

  assign edg     = level ^ sync_d;
  assign rise    = edg & level;
  assign fall    = edg & ~level;
  assign timeout = ~edg && run_cnt == LAST;

  // two-flop synchronizer plus one delayed copy for edge detection
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1     <= 1'b0;
      level  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      s1     <= led_in;
      level  <= s1;
      sync_d <= level;
    end
  end

  // cycles the current level has been held, restarting at 1 on each edge
  always_ff @(posedge clock) begin
    if (!reset_n) run_cnt <= '0;
    else if (edg) run_cnt <= CNT_WIDTH'(1);
    else if (run_cnt != '1) run_cnt <= run_cnt + 1'b1;
  end

  // any edge leaves acquisition; a timeout without an edge drops back to it
  always_comb begin
    state_nxt = state;
    if (edg) state_nxt = RUN;
    else if (timeout) state_nxt = ACQ;
  end

  // state register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= ACQ;
    else state <= state_nxt;
  end

  // latch phase lengths on edges, publish a period on the rise closing a low phase
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      high_len   <= '0;
      low_len    <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      stuck      <= 1'b0;
      have_hi    <= 1'b0;
    end else begin
      meas_valid <= state == RUN && rise && have_hi;
      if (edg) stuck <= 1'b0;
      else if (timeout) begin
        stuck   <= 1'b1;
        have_hi <= 1'b0;
      end
      if (state == RUN && fall) begin
        high_len <= run_cnt;
        have_hi  <= 1'b1;
      end
      if (state == RUN && rise) begin
        low_len <= run_cnt;
        if (have_hi) period <= (CNT_WIDTH+1)'(high_len) + (CNT_WIDTH+1)'(run_cnt);
      end
    end
  end

endmodule
